// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO: result write in cycle MUL_CYCLES+1 (mul), 33 (div) or 1 (MTx).
// One op in flight; ready only in IDLE, busy stalls the pipeline; flush aborts and squashes the write pulse.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic [1:0]  hilo_wen,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        sgn_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt;
  logic [63:0] rq;
  logic [31:0] hi_q, lo_q;
  logic [1:0]  wen_q;

  logic        accept;
  logic [31:0] a_mag_in, b_mag;
  logic [63:0] a_ext, b_ext, prod;
  logic [32:0] cand, trial;
  logic        no_borrow;
  logic [63:0] rq_step;
  logic [31:0] q_fix, r_fix;

  assign accept = op_valid && (state == S_IDLE) && !flush && (op <= 3'd5);

  // Signedness comes from op[0]: MULT/DIV are even encodings.
  assign a_mag_in = (!op[0] && src_a[31]) ? -src_a : src_a;
  assign b_mag    = (sgn_q && b_q[31]) ? -b_q : b_q;

  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  // Partial remainder can reach 33 bits after the shift; divisor never exceeds 32.
  assign cand      = {rq[63:32], rq[31]};
  assign trial     = cand - {1'b0, b_mag};
  assign no_borrow = cand[32] | ~trial[32];
  assign rq_step   = no_borrow ? {trial[31:0], rq[30:0], 1'b1}
                               : {cand[31:0],  rq[30:0], 1'b0};

  assign q_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? -rq_step[31:0] : rq_step[31:0];
  assign r_fix = (sgn_q && a_q[31]) ? -rq_step[63:32] : rq_step[63:32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op[2])      state_nxt = S_DONE;
          else if (op[1]) state_nxt = S_DIV;
          else            state_nxt = S_MUL;
        end
      end
      S_MUL:   if (cnt == 5'd0) state_nxt = S_DONE;
      S_DIV:   if (cnt == 5'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      rq    <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      wen_q <= 2'b00;
    end else begin
      wen_q <= 2'b00;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sgn_q <= ~op[0];
            a_q   <= src_a;
            b_q   <= src_b;
            rq    <= {32'd0, a_mag_in};
            cnt   <= op[1] ? 5'd31 : 5'(MUL_CYCLES - 1);
            if (op == 3'd4) begin
              hi_q  <= src_a;
              wen_q <= 2'b10;
            end else if (op == 3'd5) begin
              lo_q  <= src_a;
              wen_q <= 2'b01;
            end
          end
        end
        S_MUL: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          else if (!flush) begin
            hi_q  <= prod[63:32];
            lo_q  <= prod[31:0];
            wen_q <= 2'b11;
          end
        end
        S_DIV: begin
          rq <= rq_step;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          else if (!flush) begin
            // Divide by zero returns the raw dividend in HI and all-ones in LO.
            hi_q  <= (b_q == 32'd0) ? a_q : r_fix;
            lo_q  <= (b_q == 32'd0) ? 32'hFFFF_FFFF : q_fix;
            wen_q <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready    = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign hilo_wen = wen_q & {2{~flush}};
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It sits between the EX stage and the HI/LO register pair.
- Accepts one operation at a time and stalls the pipeline via busy.
- Runs a fixed-latency multiply and a 32-iteration restoring divide.
- Issues a single write pulse with the per-half write enables and data to HI/LO.
- flush aborts any in-flight operation and suppresses its write.

Parameters:
MUL_CYCLES, 4, cycles spent in MUL state (multicycle-path model of the multiplier); legal range 1..15.

Ports:
clk        in   1   clock, rising edge
resetn     in   1   reset, asynchronous, active-low
op_valid   in   1   operation request; sampled only when ready
op         in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x ignored (no accept)
src_a      in   32  rs operand (dividend / multiplicand / MT data)
src_b      in   32  rt operand (divisor / multiplier)
flush      in   1   exception/ERET flush; aborts current operation
ready      out  1   1 when state==IDLE
busy       out  1   1 when state!=IDLE (pipeline stall)
hilo_wen   out  2   [1]=HI write, [0]=LO write; one-cycle pulse
hi_wdata   out  32  HI write data
lo_wdata   out  32  LO write data

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, counter=0.
  - All result/operand registers 0.
  - Outputs: ready=1, busy=0, hilo_wen=00, hi_wdata=0, lo_wdata=0.
- States: IDLE, MUL, DIV, DONE.
- Cycle numbering: cycle 0 is the cycle in which op_valid & ready & ~flush & legal op is high. Accept happens at the end of cycle 0.
- IDLE, on accept, latch operands and op, then:
  - MULT/MULTU: go to MUL, counter=MUL_CYCLES-1.
  - DIV/DIVU: go to DIV, counter=31.
  - MTHI: go to DONE with wen=10, hi_wdata=src_a.
  - MTLO: go to DONE with wen=01, lo_wdata=src_a.
- MUL:
  - Product = 64-bit signed (MULT) or unsigned (MULTU) product of the latched operands.
  - Counter decrements each cycle.
  - At counter==0: go to DONE with hi=product[63:32], lo=product[31:0], wen=11.
  - Write visible in cycle MUL_CYCLES+1.
- DIV:
  - Signed ops divide magnitudes of the operands.
  - Restoring algorithm, one quotient bit per cycle: 64-bit remainder/quotient shift register, 33-bit trial subtract.
  - After 32 iterations go to DONE with wen=11. Write visible in cycle 33.
  - Signed fixup: quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (src_b==0): latency unchanged; result lo=0xFFFFFFFF, hi=src_a, no sign fixup.
- DONE:
  - hilo_wen driven for exactly this cycle, then IDLE.
  - hi_wdata/lo_wdata hold their values until the next DONE.
  - The half not written keeps stale data; it is don't-care.
  - ready=0 in DONE, so back-to-back ops have one bubble minimum.
- flush:
  - In any non-IDLE state, next state is IDLE.
  - hilo_wen is gated combinationally: hilo_wen = wen_reg & {2{~flush}}, so a flush coinciding with DONE suppresses the write.
  - flush in IDLE blocks accept that cycle.
- op_valid while busy: ignored. The requester holds it; the pipeline stalls on busy.
- Reset mid-operation: immediate return to IDLE with reset values; no write is issued.
- Counter width is 5 bits; no wrap-around beyond the load values.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, accept in cycle 0 → busy cycles 1..5 (MUL_CYCLES=4); in cycle 5 hilo_wen=11, hi=0xFFFFFFFE, lo=0x00000001; ready=1 in cycle 6.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Division results, each with hilo_wen=11 in cycle 33:
  - DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- MTHI src_a=0x12345678 → cycle 1 hilo_wen=10, hi_wdata=0x12345678; MTLO next accept → hilo_wen=01. Check the one-cycle bubble between them.
- DIV accepted, flush asserted in cycle 10 → IDLE in cycle 11, no hilo_wen pulse ever; a new MULTU accepted in cycle 11 completes normally.
- Flush coinciding with DONE: hilo_wen=00 that cycle.
- resetn dropped asynchronously mid-DIV (between clock edges) → busy=0 and hilo_wen=00 immediately. After release, no stale write occurs and ready=1.
